maze_path_stack: RTL

Location stack for the maze-solver datapath: holds the 8-bit cells ({x[7:4], y[3:0]}) of the current search path. The search controller pushes a cell when it advances, pops on backtrack, and reads `empty` to detect an unsolvable maze. After the solve, a replay engine streams the stored path from start cell to destination over a valid/ready port to the output stage, leaving the stack intact.

---
 rtl/maze_path_stack.sv | 115 +++++++++++
 1 files changed

// File: rtl/maze_path_stack.sv
// Location stack for the maze-solver path: push/pop/replace from the search
// controller, plus a non-destructive bottom-to-top replay over valid/ready.
module maze_path_stack #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned LOC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [LOC_W-1:0] loc_in,
  output logic [LOC_W-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  input  logic             dump_start,
  output logic             dump_busy,
  output logic             path_valid,
  input  logic             path_ready,
  output logic [LOC_W-1:0] path_loc,
  output logic             path_last,
  output logic             dump_done
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SP_W = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [LOC_W-1:0] mem [DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_m1;
  logic [AW-1:0]    idx;
  logic             accept;

  assign sp_m1 = sp - SP_W'(1);
  assign empty = (sp == '0);
  assign full  = (sp == SP_W'(DEPTH));
  assign top   = empty ? '0 : mem[sp_m1[AW-1:0]];

  always_comb begin
    state_d    = state_q;
    path_valid = 1'b0;
    path_loc   = '0;
    path_last  = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    accept     = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_start) state_d = empty ? FIN : DUMP;
      end
      DUMP: begin
        path_valid = 1'b1;
        dump_busy  = 1'b1;
        path_loc   = mem[idx];
        path_last  = (idx == sp_m1[AW-1:0]);
        accept     = path_ready;
        if (path_ready && path_last) state_d = FIN;
      end
      FIN: begin
        dump_busy = 1'b1;
        dump_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        state_q <= IDLE;
    else if (clear) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp       <= '0;
      idx      <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      sp       <= '0;
      overflow <= 1'b0;
    end else if (state_q == IDLE) begin
      if (dump_start && !empty) idx <= '0;
      // push+pop on an empty stack degrades to a plain push
      if (push && pop && !empty) begin
        sp <= sp;
      end else if (push) begin
        if (full) overflow <= 1'b1;
        else      sp <= sp + SP_W'(1);
      end else if (pop && !empty) begin
        sp <= sp_m1;
      end
    end else if (state_q == DUMP) begin
      if (accept && !path_last) idx <= idx + AW'(1);
    end
  end

  // Storage has no reset; empty masks stale contents on top.
  always_ff @(posedge clk) begin
    if (!clear && state_q == IDLE && push) begin
      if (pop && !empty)  mem[sp_m1[AW-1:0]] <= loc_in;
      else if (!full)     mem[sp[AW-1:0]]    <= loc_in;
    end
  end

endmodule
